// File: rtl/led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : led_pattern_ctrl
//  Purpose  : Switch-to-LED pattern engine with blink prescaler and four modes
//             (pass-through, masked blink, chase, trigger-pattern blink).
//  Revision : 1.0  initial release
// ============================================================================
module led_pattern_ctrl #(
    parameter int unsigned      WIDTH    = 4,
    parameter int unsigned      DIV_N    = 13500000,
    parameter int unsigned      CNT_W    = 26,
    parameter logic [WIDTH-1:0] TRIG_PAT = WIDTH'(4'b0110)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    input  logic [1:0]       mode,
    input  logic             dir,
    output logic [WIDTH-1:0] led,
    output logic             tick,
    output logic             phase
);

    localparam int unsigned        c_POS_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   c_CNT_LAST = CNT_W'(DIV_N - 1);
    localparam logic [c_POS_W-1:0] c_POS_LAST = c_POS_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   c_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    localparam logic [1:0] c_MODE_PASS  = 2'd0;
    localparam logic [1:0] c_MODE_BLINK = 2'd1;
    localparam logic [1:0] c_MODE_CHASE = 2'd2;

    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               tick_q,  tick_d;
    logic               phase_q, phase_d;
    logic [c_POS_W-1:0] pos_q,   pos_d;
    logic [1:0]         mode_q,  mode_d;
    logic [WIDTH-1:0]   led_q,   led_d;

    logic               w_mode_chg;
    logic               w_wrap;
    logic               w_phase_src;
    logic [c_POS_W-1:0] w_pos_src;
    logic [WIDTH-1:0]   w_onehot;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            phase_q <= 1'b0;
            pos_q   <= '0;
            mode_q  <= c_MODE_PASS;
            led_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            phase_q <= phase_d;
            pos_q   <= pos_d;
            mode_q  <= mode_d;
            led_q   <= led_d;
        end
    end

    always_comb begin
        w_mode_chg = (mode != mode_q);
        w_wrap     = (cnt_q == c_CNT_LAST);

        cnt_d   = cnt_q + CNT_W'(1);
        tick_d  = 1'b0;
        phase_d = phase_q;
        pos_d   = pos_q;
        mode_d  = mode;

        if (w_wrap) begin
            cnt_d   = '0;
            tick_d  = 1'b1;
            phase_d = ~phase_q;
            if (dir) begin
                pos_d = (pos_q == '0) ? c_POS_LAST : pos_q - c_POS_W'(1);
            end else begin
                pos_d = (pos_q == c_POS_LAST) ? '0 : pos_q + c_POS_W'(1);
            end
        end

        // A mode change restarts the pattern and suppresses a coincident tick
        if (w_mode_chg) begin
            cnt_d   = '0;
            tick_d  = 1'b0;
            phase_d = 1'b0;
            pos_d   = '0;
        end

        // The LED value for a new mode is built from the cleared state
        w_phase_src = w_mode_chg ? 1'b0 : phase_q;
        w_pos_src   = w_mode_chg ? '0   : pos_q;
        w_onehot    = c_ONE << w_pos_src;

        led_d = sw;
        case (mode)
            c_MODE_PASS:  led_d = sw;
            c_MODE_BLINK: led_d = w_phase_src ? sw : '0;
            c_MODE_CHASE: led_d = (sw != '0) ? (w_onehot & sw) : w_onehot;
            default: begin
                if (sw == TRIG_PAT) begin
                    led_d            = '1;
                    led_d[0]         = w_phase_src;
                    led_d[WIDTH-1]   = w_phase_src;
                end else begin
                    led_d = sw;
                end
            end
        endcase
    end

    assign led   = led_q;
    assign tick  = tick_q;
    assign phase = phase_q;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_pattern_ctrl
//  Purpose  : Directed self-checking bench for led_pattern_ctrl (W=4, DIV_N=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_led_pattern_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw;
    logic [1:0] mode;
    logic       dir;
    logic [3:0] led;
    logic       tick;
    logic       phase;

    int n_checks = 0;
    int n_errors = 0;

    led_pattern_ctrl #(
        .WIDTH    (4),
        .DIV_N    (4),
        .CNT_W    (3),
        .TRIG_PAT (4'b0110)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .sw    (sw),
        .mode  (mode),
        .dir   (dir),
        .led   (led),
        .tick  (tick),
        .phase (phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance n clock edges; outputs are stable 1ns after the edge
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; sw = 4'hF; mode = 2'd0; dir = 1'b0;

        // 1. reset and prescaler cadence
        step(3);
        check("rst_led",   led,   4'h0);
        check("rst_tick",  tick,  1'b0);
        check("rst_phase", phase, 1'b0);
        rst = 1'b0;
        step(1);
        check("pass_after_rst", led, 4'hF);
        check("tick_early", tick, 1'b0);
        step(2);
        check("tick_c3", tick, 1'b0);
        step(1);
        check("tick_first",  tick,  1'b1);
        check("phase_first", phase, 1'b1);
        step(1);
        check("tick_one_cycle", tick, 1'b0);
        step(3);
        check("tick_second",  tick,  1'b1);
        check("phase_second", phase, 1'b0);

        // 2. pass-through
        sw = 4'b1010; step(1);
        check("pass_1010", led, 4'b1010);
        sw = 4'b0101; step(1);
        check("pass_0101", led, 4'b0101);

        // 3. masked blink
        mode = 2'd1; sw = 4'b1001; step(1);
        check("blink_chg_led",   led,   4'b0000);
        check("blink_chg_phase", phase, 1'b0);
        check("blink_chg_tick",  tick,  1'b0);
        step(4);
        check("blink_tick_led", led, 4'b0000);
        check("blink_phase1",   phase, 1'b1);
        step(1);
        check("blink_on",      led, 4'b1001);
        step(3);
        check("blink_on_last", led, 4'b1001);
        step(1);
        check("blink_off",     led, 4'b0000);

        // 4. chase, forward with wrap then reverse with wrap
        mode = 2'd2; sw = 4'b0000; dir = 1'b0; step(1);
        check("chase_0", led, 4'b0001);
        step(4);
        check("chase_hold", led, 4'b0001);
        step(1);
        check("chase_1", led, 4'b0010);
        step(4);  check("chase_2",     led, 4'b0100);
        step(4);  check("chase_3",     led, 4'b1000);
        step(4);  check("chase_wrapF", led, 4'b0001);
        step(4);  check("chase_1b",    led, 4'b0010);
        step(4);  check("chase_2b",    led, 4'b0100);
        dir = 1'b1;
        step(4);  check("chase_rev1",  led, 4'b0010);
        step(4);  check("chase_rev0",  led, 4'b0001);
        step(4);  check("chase_wrapR", led, 4'b1000);
        // masked chase: pos keeps moving while dark
        sw = 4'b0010; step(1);
        check("chase_mask_dark", led, 4'b0000);
        step(4);  check("chase_mask_dark2", led, 4'b0000);
        step(4);  check("chase_mask_lit",   led, 4'b0010);

        // 5. trigger mode
        mode = 2'd3; sw = 4'b0110; dir = 1'b0; step(1);
        check("trig_ph0", led, 4'b0110);
        step(5);
        check("trig_ph1", led, 4'b1111);
        step(4);
        check("trig_ph0b", led, 4'b0110);
        sw = 4'b0111; step(1);
        check("trig_miss", led, 4'b0111);

        // 6. mode change coincident with tick
        mode = 2'd2; sw = 4'b0000; step(1);
        step(3);
        mode = 2'd1; step(1);
        check("coinc_tick",  tick,  1'b0);
        check("coinc_phase", phase, 1'b0);
        check("coinc_led",   led,   4'b0000);
        step(3);
        check("coinc_no_tick", tick, 1'b0);
        step(1);
        check("coinc_next_tick", tick, 1'b1);

        // reset mid-chase
        mode = 2'd2; step(1);
        step(5);
        check("pre_rst_chase", led, 4'b0010);
        rst = 1'b1; step(1);
        check("mid_rst_led",   led,   4'b0000);
        check("mid_rst_phase", phase, 1'b0);
        rst = 1'b0; step(1);
        check("post_rst_pos0", led, 4'b0001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
